// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_pkg
//  Purpose  : Shared types, widths and helpers for the data-memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_responder_pkg;

  // Bus widths of the CPU data port
  localparam int c_data_size    = 32;
  localparam int c_address_size = 32;
  // Word address width: byte address without the two byte-offset bits
  localparam int c_word_addr_w  = c_address_size - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } dm_state_t;

  // The full word address is kept so the entry layout is independent of the
  // array depth; only legal (in-range) stores ever enter the buffer.
  typedef struct packed {
    logic [c_word_addr_w-1:0] index;
    logic [c_data_size-1:0]   data;
  } wb_entry_t;

  // Word-aligned and inside an array of 2**idx_w words
  function automatic logic addr_legal(input logic [c_address_size-1:0] addr,
                                      input int unsigned                idx_w);
    return (addr[1:0] == 2'b00) && ((addr >> (idx_w + 2)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Purpose  : CPU data-memory port (loads, stores, flush handshake).
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                      dm_write_enable;
  logic [c_address_size-1:0] dm_write_address;
  logic [c_data_size-1:0]    dm_write_data;
  logic [c_address_size-1:0] dm_read_address;
  logic [c_data_size-1:0]    dm_read_data;
  logic                      dm_stall;
  logic                      flush_req;
  logic                      flush_done;
  logic                      dm_err;

  // CPU side
  modport master (
    output dm_write_enable, dm_write_address, dm_write_data,
    output dm_read_address, flush_req,
    input  dm_read_data, dm_stall, flush_done, dm_err
  );

  // Memory side
  modport slave (
    input  dm_write_enable, dm_write_address, dm_write_data,
    input  dm_read_address, flush_req,
    output dm_read_data, dm_stall, flush_done, dm_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder_wbuf.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_wbuf
//  Purpose  : Circular store buffer with youngest-match search for load
//             forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder_wbuf
  import dmem_responder_pkg::*;
#(
  parameter  int WB_DEPTH = 4,
  localparam int PW       = $clog2(WB_DEPTH),
  localparam int CW       = PW + 1
) (
  input  wire logic                     clock,
  input  wire logic                     reset_n,
  input  wire logic                     push,
  input  wire wb_entry_t                push_entry,
  input  wire logic                     pop,
  output      wb_entry_t                head,
  output      logic [CW-1:0]            count,
  output      logic                     full,
  output      logic                     empty,
  input  wire logic [c_word_addr_w-1:0] search_index,
  output      logic                     hit,
  output      logic [c_data_size-1:0]   hit_data
);

  wb_entry_t     r_entries [WB_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Pointer and occupancy bookkeeping; pointers wrap on their own width
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (!push && pop) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage needs no reset: occupancy alone decides validity
  always_ff @(posedge clock) begin
    if (push) r_entries[r_wr_ptr] <= push_entry;
  end

  assign head  = r_entries[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(WB_DEPTH));
  assign empty = (r_count == '0);

  // Walk oldest to youngest so the last match found is the youngest store
  always_comb begin
    logic [PW-1:0] pos;
    pos      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      pos = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_entries[pos].index == search_index)) begin
        hit      = 1'b1;
        hit_data = r_entries[pos].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory responder: posted stores through a throttled write
//             buffer, forwarding loads, flush handshake and sticky error.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int WB_DEPTH       = 4,
  parameter int DRAIN_INTERVAL = 4
) (
  input wire logic           clock,
  input wire logic           reset_n,
  dmem_responder_if.slave    dm
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CW    = $clog2(WB_DEPTH) + 1;
  localparam int DCW   = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;

  dm_state_t                r_state;
  dm_state_t                w_next_state;
  logic [DCW-1:0]           r_drain_cnt;
  logic                     r_flush_armed;
  logic [c_data_size-1:0]   r_read_data;
  logic                     r_err;
  logic [c_data_size-1:0]   r_mem [DEPTH_WORDS];

  logic                     w_drain_now;
  logic                     w_push;
  logic                     w_stall;
  logic                     w_wr_legal;
  logic                     w_rd_legal;
  logic                     w_flush;
  logic [CW-1:0]            w_count;
  logic [CW-1:0]            w_count_next;
  logic                     w_full;
  logic                     w_empty;
  wb_entry_t                w_push_entry;
  wb_entry_t                w_head;
  logic                     w_hit;
  logic [c_data_size-1:0]   w_hit_data;
  logic                     w_head_in_range;

  assign w_wr_legal   = addr_legal(dm.dm_write_address, IDX_W);
  assign w_rd_legal   = addr_legal(dm.dm_read_address, IDX_W);
  assign w_stall      = w_full && !w_drain_now;
  assign w_push       = dm.dm_write_enable && !w_stall && w_wr_legal;
  assign w_count_next = w_count + CW'(w_push) - CW'(w_drain_now);
  // A flush held high through DONE must drop before it can start another
  assign w_flush      = dm.flush_req && r_flush_armed;
  assign w_push_entry = '{index: dm.dm_write_address[c_address_size-1:2],
                          data:  dm.dm_write_data};

  dmem_responder_wbuf #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
    .clock        (clock),
    .reset_n      (reset_n),
    .push         (w_push),
    .push_entry   (w_push_entry),
    .pop          (w_drain_now),
    .head         (w_head),
    .count        (w_count),
    .full         (w_full),
    .empty        (w_empty),
    .search_index (dm.dm_read_address[c_address_size-1:2]),
    .hit          (w_hit),
    .hit_data     (w_hit_data)
  );

  // Pop timing: throttled in DRAIN, every cycle in FLUSH
  always_comb begin
    w_drain_now = 1'b0;
    case (r_state)
      DRAIN:   w_drain_now = (r_drain_cnt == DCW'(DRAIN_INTERVAL - 1)) && !w_empty;
      FLUSH:   w_drain_now = !w_empty;
      default: w_drain_now = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic; DONE goes to DRAIN on a store so IDLE always means empty
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_push)       w_next_state = DRAIN;
        else if (w_flush) w_next_state = DONE;
      end
      DRAIN: begin
        if (w_drain_now && (w_count == CW'(1)) && !w_push) w_next_state = IDLE;
        else if (w_flush)                                 w_next_state = FLUSH;
      end
      FLUSH: begin
        if (w_count_next == '0) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = w_push ? DRAIN : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Drain pacing counter: runs only while staying in DRAIN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drain_cnt <= '0;
    end else if ((r_state == DRAIN) && (w_next_state == DRAIN)) begin
      if (r_drain_cnt == DCW'(DRAIN_INTERVAL - 1)) r_drain_cnt <= '0;
      else                                         r_drain_cnt <= r_drain_cnt + 1'b1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Flush re-arm: consumed in DONE, restored once the request drops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                r_flush_armed <= 1'b1;
    else if (!dm.flush_req)      r_flush_armed <= 1'b1;
    else if (r_state == DONE)    r_flush_armed <= 1'b0;
  end

  // Buffered entries are legal by construction; the guard keeps a stray
  // out-of-range index from aliasing into the array
  assign w_head_in_range = ((w_head.index >> IDX_W) == '0);

  // Commit the oldest entry to the word array (array is not reset)
  always_ff @(posedge clock) begin
    if (w_drain_now && w_head_in_range) r_mem[w_head.index[IDX_W-1:0]] <= w_head.data;
  end

  // Registered load: sees buffer and array as they were before this edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        r_read_data <= '0;
    else if (!w_rd_legal) r_read_data <= '0;
    else if (w_hit)      r_read_data <= w_hit_data;
    else                 r_read_data <= r_mem[dm.dm_read_address[IDX_W+1:2]];
  end

  // Sticky error: illegal load, illegal store or store while stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else if (!w_rd_legal || (dm.dm_write_enable && (w_stall || !w_wr_legal)))
      r_err <= 1'b1;
  end

  assign dm.dm_read_data = r_read_data;
  assign dm.dm_stall     = w_stall;
  assign dm.flush_done   = (r_state == DONE);
  assign dm.dm_err       = r_err;

endmodule
`default_nettype wire
